// File: rtl/axi_pkg.sv
// ---------------------------------------------------------------------------
// axi_pkg
// Shared constants and types for the AXI-style register file responder.
//   ADDR_W / DATA_W      : address and data widths of the register file
//   RAM_DEPTH            : number of read/write RAM words (0x0..0xB)
//   ADDR_ID / ADDR_WCOUNT: read-only ID and write-counter addresses
//   RESP_OKAY/SLVERR     : response encodings
//   wr_state_t/rd_state_t: write and read FSM state encodings
// ---------------------------------------------------------------------------
package axi_pkg;

  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 12;

  localparam logic [ADDR_W-1:0] ADDR_ID     = 4'hC;
  localparam logic [ADDR_W-1:0] ADDR_WCOUNT = 4'hD;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // True for addresses that map onto the writable RAM.
  function automatic logic is_ram_addr(input logic [ADDR_W-1:0] a);
    return a < ADDR_W'(RAM_DEPTH);
  endfunction

endpackage

// File: rtl/axi_regbank.sv
// ---------------------------------------------------------------------------
// axi_regbank
// Storage and read decode for the register file: 12x8 RAM, saturating count
// of successful writes, and the read-only ID register.
// Ports:
//   clk, i_rst_n        : clock, asynchronous active-low reset
//   i_we                : write commit strobe (one cycle)
//   i_waddr, i_wdata    : commit address and data
//   o_wr_ok             : commit address is writable (drives OKAY/SLVERR)
//   i_raddr             : read address (combinational decode)
//   o_rdata, o_rd_ok    : decoded read data and legality
// ---------------------------------------------------------------------------
module axi_regbank
  import axi_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_wr_ok,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rd_ok
);

  logic [DATA_W-1:0]    r_ram [RAM_DEPTH];
  logic [DATA_W-1:0]    r_wcount;
  logic [RAM_DEPTH-1:0] w_word_we;

  assign o_wr_ok = is_ram_addr(i_waddr);

  // One-hot word enables; writes to ID/WCOUNT/unmapped hit no word.
  generate
    for (genvar gi = 0; gi < RAM_DEPTH; gi++) begin : g_word_we
      assign w_word_we[gi] = i_we & (i_waddr == ADDR_W'(gi));
    end
  endgenerate

  // RAM is cleared on reset, so it is built from registers.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        r_ram[i] <= '0;
      end
    end else begin
      for (int i = 0; i < RAM_DEPTH; i++) begin
        if (w_word_we[i]) begin
          r_ram[i] <= i_wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wcount <= '0;
    end else if (i_we && o_wr_ok && (r_wcount != {DATA_W{1'b1}})) begin
      r_wcount <= r_wcount + DATA_W'(1);
    end
  end

  always_comb begin
    o_rdata = '0;
    o_rd_ok = 1'b0;
    if (is_ram_addr(i_raddr)) begin
      o_rd_ok = 1'b1;
      for (int i = 0; i < RAM_DEPTH; i++) begin
        if (i_raddr == ADDR_W'(i)) begin
          o_rdata = r_ram[i];
        end
      end
    end else if (i_raddr == ADDR_ID) begin
      o_rd_ok = 1'b1;
      o_rdata = ID_VALUE;
    end else if (i_raddr == ADDR_WCOUNT) begin
      o_rd_ok = 1'b1;
      o_rdata = r_wcount;
    end
  end

endmodule

// File: rtl/axi_regfile_responder.sv
// ---------------------------------------------------------------------------
// axi_regfile_responder
// AXI-lite-style slave over a small register file. Write address and write
// data are buffered independently; the write commits when both are present
// and a response is held until accepted. The read channel runs concurrently
// with a one-cycle registered read.
// Ports:
//   clk, rst                          : clock, asynchronous active-low reset
//   write_address, AW_VALID, AW_READY : write address channel
//   write_data, W_VALID, W_READY      : write data channel
//   B_VALID, B_READY, B_RESP          : write response channel
//   read_address, AR_VALID, AR_READY  : read address channel
//   data_read, R_VALID, R_READY, R_RESP : read data channel
// ---------------------------------------------------------------------------
module axi_regfile_responder
  import axi_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] write_address,
  input  logic              AW_VALID,
  output logic              AW_READY,
  input  logic [DATA_W-1:0] write_data,
  input  logic              W_VALID,
  output logic              W_READY,
  output logic              B_VALID,
  input  logic              B_READY,
  output logic [1:0]        B_RESP,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              AR_VALID,
  output logic              AR_READY,
  output logic [DATA_W-1:0] data_read,
  output logic              R_VALID,
  input  logic              R_READY,
  output logic [1:0]        R_RESP
);

  // ---------------- write channel ----------------
  wr_state_t         r_wstate;
  wr_state_t         w_wstate_next;
  logic              r_aw_full;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_full;
  logic [DATA_W-1:0] r_w_data;
  logic [1:0]        r_bresp;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_ok;

  // Ready outputs are gated by rst so they stay low while reset is held.
  assign AW_READY = rst & ~r_aw_full & (r_wstate == W_IDLE);
  assign W_READY  = rst & ~r_w_full  & (r_wstate == W_IDLE);
  assign w_aw_hs  = AW_VALID & AW_READY;
  assign w_w_hs   = W_VALID & W_READY;

  // Commit on the edge where both halves are available, whether they were
  // buffered earlier or are handshaking right now.
  assign w_commit = (r_wstate == W_IDLE) & (r_aw_full | w_aw_hs) & (r_w_full | w_w_hs);
  assign w_waddr  = r_aw_full ? r_aw_addr : write_address;
  assign w_wdata  = r_w_full ? r_w_data : write_data;

  assign B_VALID = (r_wstate == W_RESP);
  assign B_RESP  = r_bresp;

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      W_IDLE: if (w_commit) w_wstate_next = W_RESP;
      W_RESP: if (B_READY)  w_wstate_next = W_IDLE;
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
    end
  end

  // Buffers stay full through W_RESP, which keeps AW/W_READY low until the
  // response is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_bresp   <= RESP_OKAY;
    end else begin
      if ((r_wstate == W_RESP) && B_READY) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_full <= 1'b1;
          r_aw_addr <= write_address;
        end
        if (w_w_hs) begin
          r_w_full <= 1'b1;
          r_w_data <= write_data;
        end
      end
      if (w_commit) begin
        r_bresp <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t         r_rstate;
  rd_state_t         w_rstate_next;
  logic [DATA_W-1:0] r_data_read;
  logic [1:0]        r_rresp;
  logic              w_ar_hs;
  logic [DATA_W-1:0] w_rdata;
  logic              w_rd_ok;

  assign AR_READY  = rst & (r_rstate == R_IDLE);
  assign w_ar_hs   = AR_VALID & AR_READY;
  assign R_VALID   = (r_rstate == R_DATA);
  assign data_read = r_data_read;
  assign R_RESP    = r_rresp;

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_next = R_DATA;
      R_DATA: if (R_READY) w_rstate_next = R_IDLE;
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rstate <= R_IDLE;
    end else begin
      r_rstate <= w_rstate_next;
    end
  end

  // Read data is sampled from the pre-edge RAM contents, so a write
  // committing on the same edge is not yet visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data_read <= '0;
      r_rresp     <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_data_read <= w_rdata;
      r_rresp     <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  axi_regbank #(
    .ID_VALUE(ID_VALUE)
  ) u_regbank (
    .clk     (clk),
    .i_rst_n (rst),
    .i_we    (w_commit),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .o_wr_ok (w_wr_ok),
    .i_raddr (read_address),
    .o_rdata (w_rdata),
    .o_rd_ok (w_rd_ok)
  );

endmodule

// File: tb/tb_axi_regfile_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_regfile_responder
// Directed bench for axi_regfile_responder: reset, basic write/read,
// out-of-order and same-edge write halves, error responses, backpressure,
// read/write collision, reset abort and counter saturation.
// ---------------------------------------------------------------------------
module tb_axi_regfile_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] write_address = '0;
  logic       AW_VALID = 1'b0;
  logic       AW_READY;
  logic [7:0] write_data = '0;
  logic       W_VALID = 1'b0;
  logic       W_READY;
  logic       B_VALID;
  logic       B_READY = 1'b0;
  logic [1:0] B_RESP;
  logic [3:0] read_address = '0;
  logic       AR_VALID = 1'b0;
  logic       AR_READY;
  logic [7:0] data_read;
  logic       R_VALID;
  logic       R_READY = 1'b0;
  logic [1:0] R_RESP;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axi_regfile_responder #(.ID_VALUE(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .write_address(write_address),
    .AW_VALID     (AW_VALID),
    .AW_READY     (AW_READY),
    .write_data   (write_data),
    .W_VALID      (W_VALID),
    .W_READY      (W_READY),
    .B_VALID      (B_VALID),
    .B_READY      (B_READY),
    .B_RESP       (B_RESP),
    .read_address (read_address),
    .AR_VALID     (AR_VALID),
    .AR_READY     (AR_READY),
    .data_read    (data_read),
    .R_VALID      (R_VALID),
    .R_READY      (R_READY),
    .R_RESP       (R_RESP)
  );

  // Inputs change and outputs are observed 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    B_READY = 1'b0; R_READY = 1'b0;
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // Write with AW and W presented together; lat = edges from last handshake
  // until B_VALID is seen.
  task automatic wr(input logic [3:0] a, input logic [7:0] d,
                    output logic [1:0] resp, output int lat);
    int  n;
    logic aw_hs, w_hs;
    write_address = a; write_data = d;
    AW_VALID = 1'b1; W_VALID = 1'b1; B_READY = 1'b1;
    n = 0;
    while ((AW_VALID || W_VALID) && n < 50) begin
      aw_hs = AW_VALID & AW_READY;
      w_hs  = W_VALID & W_READY;
      tick();
      if (aw_hs) AW_VALID = 1'b0;
      if (w_hs)  W_VALID = 1'b0;
      n++;
    end
    AW_VALID = 1'b0; W_VALID = 1'b0;
    lat = 1;
    while (!B_VALID && lat < 50) begin
      tick();
      lat++;
    end
    resp = B_RESP;
    tick();
    B_READY = 1'b0;
    $display("WRITE addr=%h data=%h resp=%b lat=%0d", a, d, resp, lat);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] d,
                    output logic [1:0] resp, output int lat);
    int n;
    read_address = a; AR_VALID = 1'b1; R_READY = 1'b1;
    n = 0;
    while (!AR_READY && n < 50) begin
      tick();
      n++;
    end
    tick();
    AR_VALID = 1'b0;
    lat = 1;
    while (!R_VALID && lat < 50) begin
      tick();
      lat++;
    end
    d = data_read; resp = R_RESP;
    tick();
    R_READY = 1'b0;
    $display("READ  addr=%h data=%h resp=%b lat=%0d", a, d, resp, lat);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    tick(); tick();
    checks++;
    if ({AW_READY, W_READY, AR_READY} !== 3'b000) begin
      failures++;
      $display("FAIL reset_readies actual=%b expected=000", {AW_READY, W_READY, AR_READY});
    end
    checks++;
    if ({B_VALID, R_VALID} !== 2'b00) begin
      failures++;
      $display("FAIL reset_valids actual=%b expected=00", {B_VALID, R_VALID});
    end
    checks++;
    if ({B_RESP, R_RESP, data_read} !== 12'h000) begin
      failures++;
      $display("FAIL reset_payload actual=%h expected=000", {B_RESP, R_RESP, data_read});
    end
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({AW_READY, W_READY, AR_READY} !== 3'b111) begin
      failures++;
      $display("FAIL release_readies actual=%b expected=111", {AW_READY, W_READY, AR_READY});
    end
    tick();
  endtask

  task automatic test_basic();
    logic [7:0] d; logic [1:0] r; int lat;
    write_address = 4'h6; AW_VALID = 1'b1; B_READY = 1'b1;
    tick();
    AW_VALID = 1'b0;
    checks++;
    if ({AW_READY, W_READY, B_VALID} !== 3'b010) begin
      failures++;
      $display("FAIL basic_aw_buffered actual=%b expected=010", {AW_READY, W_READY, B_VALID});
    end
    tick();
    write_data = 8'hAA; W_VALID = 1'b1;
    tick();
    W_VALID = 1'b0;
    checks++;
    if ({B_VALID, B_RESP} !== 3'b100) begin
      failures++;
      $display("FAIL basic_bvalid actual=%b expected=100", {B_VALID, B_RESP});
    end
    tick();
    B_READY = 1'b0;
    checks++;
    if ({B_VALID, AW_READY, W_READY} !== 3'b011) begin
      failures++;
      $display("FAIL basic_b_done actual=%b expected=011", {B_VALID, AW_READY, W_READY});
    end
    $display("WRITE addr=6 data=aa split AW/W");
    rd(4'h6, d, r, lat);
    checks++;
    if ({d, r} !== {8'hAA, 2'b00} || lat != 1) begin
      failures++;
      $display("FAIL basic_read actual=%h/%b lat=%0d expected=aa/00 lat=1", d, r, lat);
    end
  endtask

  task automatic test_order();
    logic [7:0] d; logic [1:0] r; int lat;
    do_reset();
    write_data = 8'h55; W_VALID = 1'b1; B_READY = 1'b1;
    tick();
    W_VALID = 1'b0;
    checks++;
    if ({AW_READY, W_READY, B_VALID} !== 3'b100) begin
      failures++;
      $display("FAIL order_w_buffered actual=%b expected=100", {AW_READY, W_READY, B_VALID});
    end
    tick();
    write_address = 4'h3; AW_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0;
    checks++;
    if ({B_VALID, B_RESP} !== 3'b100) begin
      failures++;
      $display("FAIL order_w_first_resp actual=%b expected=100", {B_VALID, B_RESP});
    end
    tick();
    $display("WRITE addr=3 data=55 W before AW");
    wr(4'h4, 8'h66, r, lat);
    checks++;
    if (r !== 2'b00 || lat != 1) begin
      failures++;
      $display("FAIL order_same_edge_resp actual=%b lat=%0d expected=00 lat=1", r, lat);
    end
    rd(4'h3, d, r, lat);
    checks++;
    if ({d, r} !== {8'h55, 2'b00}) begin
      failures++;
      $display("FAIL order_read3 actual=%h/%b expected=55/00", d, r);
    end
    rd(4'h4, d, r, lat);
    checks++;
    if ({d, r} !== {8'h66, 2'b00}) begin
      failures++;
      $display("FAIL order_read4 actual=%h/%b expected=66/00", d, r);
    end
    rd(4'hD, d, r, lat);
    checks++;
    if ({d, r} !== {8'h02, 2'b00}) begin
      failures++;
      $display("FAIL order_wcount actual=%h/%b expected=02/00", d, r);
    end
  endtask

  task automatic test_errors();
    logic [7:0] d; logic [1:0] r; int lat;
    wr(4'hC, 8'h77, r, lat);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("FAIL err_write_id actual=%b expected=10", r);
    end
    wr(4'hE, 8'h88, r, lat);
    checks++;
    if (r !== 2'b10) begin
      failures++;
      $display("FAIL err_write_unmapped actual=%b expected=10", r);
    end
    rd(4'hD, d, r, lat);
    checks++;
    if ({d, r} !== {8'h02, 2'b00}) begin
      failures++;
      $display("FAIL err_wcount_unchanged actual=%h/%b expected=02/00", d, r);
    end
    rd(4'hC, d, r, lat);
    checks++;
    if ({d, r} !== {8'hA5, 2'b00}) begin
      failures++;
      $display("FAIL err_read_id actual=%h/%b expected=a5/00", d, r);
    end
    rd(4'hF, d, r, lat);
    checks++;
    if ({d, r} !== {8'h00, 2'b10} || lat != 1) begin
      failures++;
      $display("FAIL err_read_unmapped actual=%h/%b lat=%0d expected=00/10 lat=1", d, r, lat);
    end
    rd(4'h0, d, r, lat);
    checks++;
    if ({d, r} !== {8'h00, 2'b00}) begin
      failures++;
      $display("FAIL err_ram0_untouched actual=%h/%b expected=00/00", d, r);
    end
    wr(4'hB, 8'h5A, r, lat);
    checks++;
    if (r !== 2'b00) begin
      failures++;
      $display("FAIL err_write_top_ram actual=%b expected=00", r);
    end
    rd(4'hB, d, r, lat);
    checks++;
    if ({d, r} !== {8'h5A, 2'b00}) begin
      failures++;
      $display("FAIL err_read_top_ram actual=%h/%b expected=5a/00", d, r);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d; logic [1:0] r; int lat;
    write_address = 4'h5; write_data = 8'h99; read_address = 4'h3;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    B_READY = 1'b0; R_READY = 1'b0;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({B_VALID, B_RESP, R_VALID, R_RESP, data_read} !== {1'b1, 2'b00, 1'b1, 2'b00, 8'h55}) begin
        failures++;
        $display("FAIL bp_hold_%0d actual=%b/%b/%b/%b/%h expected=1/00/1/00/55",
                 i, B_VALID, B_RESP, R_VALID, R_RESP, data_read);
      end
      checks++;
      if ({AW_READY, W_READY, AR_READY} !== 3'b000) begin
        failures++;
        $display("FAIL bp_ready_low_%0d actual=%b expected=000", i, {AW_READY, W_READY, AR_READY});
      end
      AW_VALID = 1'b1; AR_VALID = 1'b1; write_address = 4'h7; read_address = 4'h7;
      tick();
      AW_VALID = 1'b0; AR_VALID = 1'b0;
    end
    B_READY = 1'b1; R_READY = 1'b1;
    tick();
    B_READY = 1'b0; R_READY = 1'b0;
    checks++;
    if ({B_VALID, R_VALID, AW_READY, W_READY, AR_READY} !== 5'b00111) begin
      failures++;
      $display("FAIL bp_release actual=%b expected=00111", {B_VALID, R_VALID, AW_READY, W_READY, AR_READY});
    end
    $display("CONCURRENT write 5=99 read 3 under backpressure");
    rd(4'h5, d, r, lat);
    checks++;
    if ({d, r} !== {8'h99, 2'b00}) begin
      failures++;
      $display("FAIL bp_read5 actual=%h/%b expected=99/00", d, r);
    end
    rd(4'h7, d, r, lat);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL bp_no_extra_write actual=%h expected=00", d);
    end
  endtask

  task automatic test_same_edge();
    logic [7:0] d; logic [1:0] r; int lat;
    wr(4'h2, 8'h11, r, lat);
    write_address = 4'h2; write_data = 8'h22; read_address = 4'h2;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    B_READY = 1'b1; R_READY = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    checks++;
    if ({R_VALID, data_read, B_VALID} !== {1'b1, 8'h11, 1'b1}) begin
      failures++;
      $display("FAIL collide_old_value actual=%b/%h/%b expected=1/11/1", R_VALID, data_read, B_VALID);
    end
    tick();
    B_READY = 1'b0; R_READY = 1'b0;
    $display("COLLIDE read 2 with write 2=22 same edge");
    rd(4'h2, d, r, lat);
    checks++;
    if ({d, r} !== {8'h22, 2'b00}) begin
      failures++;
      $display("FAIL collide_new_value actual=%h/%b expected=22/00", d, r);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d; logic [1:0] r; int lat;
    wr(4'h6, 8'h3C, r, lat);
    write_address = 4'h6; write_data = 8'hC3; read_address = 4'h6;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    checks++;
    if ({B_VALID, R_VALID} !== 2'b11) begin
      failures++;
      $display("FAIL abort_pending actual=%b expected=11", {B_VALID, R_VALID});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({B_VALID, R_VALID, AW_READY, AR_READY, data_read} !== 12'h000) begin
      failures++;
      $display("FAIL abort_immediate actual=%h expected=000", {B_VALID, R_VALID, AW_READY, AR_READY, data_read});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    $display("RESET during pending B and R");
    rd(4'h6, d, r, lat);
    checks++;
    if ({d, r} !== {8'h00, 2'b00}) begin
      failures++;
      $display("FAIL abort_ram_cleared actual=%h/%b expected=00/00", d, r);
    end
    rd(4'hD, d, r, lat);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL abort_wcount_cleared actual=%h expected=00", d);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] d; logic [1:0] r; int lat;
    for (int i = 0; i < 255; i++) begin
      wr(4'h0, 8'(i), r, lat);
    end
    rd(4'hD, d, r, lat);
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL sat_reach_ff actual=%h expected=ff", d);
    end
    wr(4'h1, 8'hEE, r, lat);
    rd(4'hD, d, r, lat);
    checks++;
    if (d !== 8'hFF) begin
      failures++;
      $display("FAIL sat_hold_ff actual=%h expected=ff", d);
    end
    rd(4'h0, d, r, lat);
    checks++;
    if (d !== 8'hFE) begin
      failures++;
      $display("FAIL sat_last_word actual=%h expected=fe", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_errors();
    test_backpressure();
    test_same_edge();
    test_reset_abort();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
